// File: rtl/reg_check_harness.sv
// Register-file check harness: lets the processor run for a cycle budget, stalls it,
// then sweeps every register against an expected-value table. Optional macro: REG_CHECK_WRITE_TRACE_EN.
module reg_check_harness #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int CYC_W    = 20
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [CYC_W-1:0]  num_cycles,
   input  logic [ADDR_W-1:0] proc_rs1,
   output logic [ADDR_W-1:0] rs1_out,
   input  logic [DATA_W-1:0] reg_data,
   output logic [ADDR_W-1:0] exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   input  logic              rwe,
   input  logic [ADDR_W-1:0] rd,
   output logic              proc_stall,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_count,
   output logic              first_fail_valid,
   output logic [ADDR_W-1:0] first_fail_reg
`ifdef REG_CHECK_WRITE_TRACE_EN
   ,
   output logic [CYC_W-1:0]  write_count
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RUN    = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state, next_state;
   logic [CYC_W-1:0]  cnt, next_cnt;
   logic [ADDR_W-1:0] idx, next_idx;
   logic [ADDR_W:0]   next_err;
   logic              next_ffv;
   logic [ADDR_W-1:0] next_ffr;
   logic              mismatch;

`ifdef REG_CHECK_WRITE_TRACE_EN
   logic [CYC_W-1:0]  wc, next_wc;
   assign write_count = wc;
`else
   logic unused_trace;
   assign unused_trace = ^{rwe, rd};
`endif

   // The stall flag is a flop that mirrors SETTLE/CHECK/DONE, so the address mux follows the state.
   assign rs1_out  = proc_stall ? idx : proc_rs1;
   assign exp_addr = idx;

   // Next-state and next-value logic for the sequencer and result registers.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_idx   = idx;
      next_err   = err_count;
      next_ffv   = first_fail_valid;
      next_ffr   = first_fail_reg;
      mismatch   = 1'b0;
`ifdef REG_CHECK_WRITE_TRACE_EN
      next_wc    = wc;
`endif
      case (state)
         IDLE, DONE: begin
            if (start) begin
               next_cnt   = num_cycles;
               next_idx   = '0;
               next_err   = '0;
               next_ffv   = 1'b0;
               next_ffr   = '0;
`ifdef REG_CHECK_WRITE_TRACE_EN
               next_wc    = '0;
`endif
               next_state = (num_cycles == '0) ? SETTLE : RUN;
            end else begin
               next_state = state;
            end
         end
         RUN: begin
            next_cnt = cnt - CYC_W'(1);
`ifdef REG_CHECK_WRITE_TRACE_EN
            if (rwe && (rd != '0) && (wc != {CYC_W{1'b1}})) begin
               next_wc = wc + CYC_W'(1);
            end else begin
               next_wc = wc;
            end
`endif
            if (cnt == CYC_W'(1)) begin
               next_state = SETTLE;
            end else begin
               next_state = RUN;
            end
         end
         SETTLE: begin
            next_idx   = '0;
            next_state = CHECK;
         end
         CHECK: begin
            mismatch = (reg_data != exp_data);
            if (mismatch) begin
               next_err = err_count + (ADDR_W + 1)'(1);
               if (!first_fail_valid) begin
                  next_ffv = 1'b1;
                  next_ffr = idx;
               end else begin
                  next_ffv = first_fail_valid;
               end
            end else begin
               next_err = err_count;
            end
            // Index parks on the last register once the sweep completes.
            if (idx == LAST_IDX) begin
               next_state = DONE;
            end else begin
               next_idx   = idx + ADDR_W'(1);
               next_state = CHECK;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State, datapath and status registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         cnt              <= '0;
         idx              <= '0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_reg   <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         proc_stall       <= 1'b0;
`ifdef REG_CHECK_WRITE_TRACE_EN
         wc               <= '0;
`endif
      end else begin
         state            <= next_state;
         cnt              <= next_cnt;
         idx              <= next_idx;
         err_count        <= next_err;
         first_fail_valid <= next_ffv;
         first_fail_reg   <= next_ffr;
         busy             <= (next_state == RUN) || (next_state == SETTLE) || (next_state == CHECK);
         done             <= (next_state == DONE);
         pass             <= (next_state == DONE) && (next_err == '0);
         proc_stall       <= (next_state == SETTLE) || (next_state == CHECK) || (next_state == DONE);
`ifdef REG_CHECK_WRITE_TRACE_EN
         wc               <= next_wc;
`endif
      end
   end

endmodule

// File: doc/reg_check_harness.md
REG_CHECK_HARNESS -- requirements
Module: reg_check_harness

Interface
REQ-001 Parameter DATA_W, default 32: register data width.
REQ-002 Parameter NUM_REGS, default 32: registers checked, 2..2^ADDR_W.
REQ-003 Parameter ADDR_W, default 5: register index width.
REQ-004 Parameter CYC_W, default 20: cycle-budget and write-counter width.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse; begins a run.
REQ-008 num_cycles  in  CYC_W  run-phase cycle budget, sampled when start is accepted.
REQ-009 proc_rs1  in  ADDR_W  processor read-port-A address.
REQ-010 rs1_out  out  ADDR_W  regfile read-port-A address after test-mode mux.
REQ-011 reg_data  in  DATA_W  regfile port-A data, combinational from rs1_out.
REQ-012 exp_addr  out  ADDR_W  expected-value table index.
REQ-013 exp_data  in  DATA_W  expected value, combinational from exp_addr.
REQ-014 rwe  in  1, rd  in  ADDR_W  processor regfile write enable and destination.
REQ-015 proc_stall  out  1  processor hold request.
REQ-016 busy, done, pass  out  1 each  status flags.
REQ-017 err_count  out  ADDR_W+1  mismatching register count.
REQ-018 first_fail_valid  out  1, first_fail_reg  out  ADDR_W  lowest failing index.
REQ-019 write_count  out  CYC_W  traced writes; exists only with WRITE_TRACE_EN.

Function
REQ-020 FSM states IDLE, RUN, SETTLE, CHECK, DONE, registered.
REQ-021 IDLE or DONE with start=1: load cycle counter with num_cycles; clear err_count, first_fail_*, write_count; next state RUN, or SETTLE if num_cycles==0.
REQ-022 start is ignored in RUN, SETTLE and CHECK.
REQ-023 RUN lasts exactly num_cycles cycles: counter decrements each cycle; the cycle it reads 1 goes to SETTLE.
REQ-024 In IDLE and RUN, rs1_out = proc_rs1 and proc_stall = 0.
REQ-025 In SETTLE, CHECK and DONE, proc_stall = 1 and rs1_out = exp_addr = test index.
REQ-026 SETTLE lasts one cycle with test index 0; no compare.
REQ-027 CHECK lasts NUM_REGS cycles, test index 0..NUM_REGS-1, incrementing by 1; register 0 is included.
REQ-028 Each CHECK cycle compares reg_data against exp_data bitwise; on mismatch, err_count increments at the next edge.
REQ-029 On first mismatch of a run, first_fail_reg latches the index and first_fail_valid is set; later mismatches do not change them.
REQ-030 After index NUM_REGS-1, next state is DONE; test index holds at NUM_REGS-1.
REQ-031 busy = 1 in RUN, SETTLE and CHECK; done = 1 only in DONE; pass = done AND err_count==0.
REQ-032 DONE holds all results until start or reset.

Reset
REQ-033 Reset at any edge, including mid-RUN or mid-CHECK, forces IDLE and clears the counter, test index, err_count, first_fail_* and write_count.
REQ-034 Reset outputs: busy=0, done=0, pass=0, proc_stall=0, rs1_out=proc_rs1, err_count=0, first_fail_valid=0, first_fail_reg=0.
REQ-035 reset has priority over start in the same cycle.

Configuration
REQ-036 Macro REG_CHECK_WRITE_TRACE_EN defined: in RUN, write_count increments each cycle with rwe=1 and rd!=0, saturating at 2^CYC_W-1; held outside RUN.
REQ-037 Macro undefined: write_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-038 start with num_cycles=5: busy rises next edge; SETTLE entered after exactly 5 RUN cycles; done 1+NUM_REGS cycles later.
REQ-039 All reg_data==exp_data: done=1, pass=1, err_count=0, first_fail_valid=0.
REQ-040 Mismatch at regs 3 and 17: err_count=2, first_fail_reg=3, first_fail_valid=1, pass=0.
REQ-041 num_cycles=0: RUN skipped, SETTLE entered on the edge after start; start pulsed during CHECK has no effect.
REQ-042 Reset asserted during CHECK at index 10: next edge in IDLE, all status cleared, rs1_out tracks proc_rs1.
REQ-043 With REG_CHECK_WRITE_TRACE_EN, num_cycles=8, rwe=1 for 4 cycles (one with rd=0): write_count=3.
